// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Counts rising edges of a slow asynchronous square wave over a
//            fixed window of clk cycles and reports the saturated count.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
    parameter int GATE_CYC = 50000000,
    parameter int HZ_W     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            sig_in,
    output logic [HZ_W-1:0] hz_meas,
    output logic            meas_valid,
    output logic            ovf,
    output logic            busy
);

    localparam int              GW        = $clog2(GATE_CYC);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYC - 1);
    localparam logic [HZ_W-1:0] CNT_MAX   = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic            dly_q;
    logic [GW-1:0]   gate_cnt_q;
    logic [HZ_W-1:0] edge_cnt_q;
    logic [HZ_W-1:0] edge_cnt_d;
    logic            sat_q;
    logic            sat_d;
    logic [HZ_W-1:0] hz_q;
    logic            valid_q;
    logic            ovf_q;
    logic            busy_q;
    logic            edge_p;
    logic            at_max;
    logic            win_last;

    // Edge count including the current cycle; saturation is sticky per window.
    always_comb begin
        edge_p     = sync_q[1] & ~dly_q;
        at_max     = (edge_cnt_q == CNT_MAX);
        win_last   = (gate_cnt_q == GATE_LAST);
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        if (edge_p) begin
            if (at_max) begin
                sat_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + HZ_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            dly_q      <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            hz_q       <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Synchronizer runs in every state so en rise never sees a stale edge.
            sync_q  <= {sync_q[0], sig_in};
            dly_q   <= sync_q[1];
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    sat_q      <= 1'b0;
                    if (en) begin
                        state_q <= S_GATE;
                        busy_q  <= 1'b1;
                    end
                end
                S_GATE: begin
                    if (!en) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else if (win_last) begin
                        hz_q       <= edge_cnt_d;
                        ovf_q      <= sat_d;
                        valid_q    <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GW'(1);
                        edge_cnt_q <= edge_cnt_d;
                        sat_q      <= sat_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hz_meas    = hz_q;
    assign meas_valid = valid_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// Testbench for freq_meter: table of square-wave patterns with a scoreboard of
// expected window results, plus abort, reset and window-boundary sequences.
module tb_freq_meter;

    localparam int GC = 100;
    localparam int HW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sig_in;
    logic [HW-1:0] hz;
    logic          mv;
    logic          ovf;
    logic          busy;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYC(GC), .HZ_W(HW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .hz_meas   (hz),
        .meas_valid(mv),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct packed {
        logic [HW-1:0] hz;
        logic          ovf;
    } exp_t;

    typedef struct {
        int            period;
        bit            lvl;
        int            nwin;
        logic [HW-1:0] hz;
        bit            ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   total  = 0;
    int   bad    = 0;
    int   ph     = 0;
    int   period = 0;
    bit   lvl    = 1'b0;
    int   cyc    = 0;
    int   last_v = -1;
    int   gap    = 0;
    bit   vseen  = 1'b0;
    int   n;
    int   k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int h, input bit o);
        exp_t e;
        e.hz  = HW'(h);
        e.ovf = o;
        sb.push_back(e);
    endtask

    // One clock: sample outputs on the falling edge, score any result, then
    // advance the stimulus waveform.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        vseen = (mv === 1'b1);
        if (vseen) begin
            if (last_v >= 0) gap = cyc - last_v;
            last_v = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got hz=%0d ovf=%0d with no result pending", hz, ovf);
            end else begin
                e = sb.pop_front();
                chk("hz_meas", 32'(hz), 32'(e.hz));
                chk("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
        ph++;
        sig_in = (period == 0) ? lvl : ((ph % period) < (period / 2));
    endtask

    task automatic drain(input int bound);
        int c;
        c = 0;
        while (sb.size() != 0 && c < bound) begin
            step();
            c++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_valid(input int bound, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!vseen && cnt < bound);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        vecs[0] = '{20,  1'b0, 2, 4'd5,  1'b0};
        vecs[1] = '{0,   1'b0, 2, 4'd0,  1'b0};
        vecs[2] = '{0,   1'b1, 2, 4'd0,  1'b0};
        vecs[3] = '{4,   1'b0, 2, 4'd15, 1'b1};
        vecs[4] = '{50,  1'b0, 2, 4'd2,  1'b0};
        vecs[5] = '{10,  1'b0, 1, 4'd10, 1'b0};
        vecs[6] = '{6,   1'b0, 1, 4'd15, 1'b1};
        vecs[7] = '{100, 1'b0, 1, 4'd1,  1'b0};
        vecs[8] = '{25,  1'b0, 1, 4'd4,  1'b0};

        repeat (3) step();
        chk("rst_hz", 32'(hz), 32'd0);
        chk("rst_valid", 32'(mv), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            en     = 1'b0;
            period = vecs[i].period;
            lvl    = vecs[i].lvl;
            repeat (10) step();
            for (int w = 0; w < vecs[i].nwin; w++) push(int'(vecs[i].hz), vecs[i].ovf);
            en = 1'b1;
            step();
            step();
            chk("gate_busy", 32'(busy), 32'd1);
            drain(vecs[i].nwin * GC + 200);
            if (vecs[i].nwin >= 2) chk("valid_period", 32'(gap), 32'(GC));
        end

        // Abort at gate_cnt=60, re-raise 10 clk later.
        en     = 1'b0;
        period = 20;
        repeat (10) step();
        push(5, 1'b0);
        en = 1'b1;
        drain(300);
        repeat (60) step();
        en = 1'b0;
        repeat (10) step();
        chk("abort_hold_hz", 32'(hz), 32'd5);
        chk("abort_hold_ovf", 32'(ovf), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        push(5, 1'b0);
        en = 1'b1;
        wait_valid(300, n);
        chk("reraise_latency", 32'(n), 32'(GC + 1));

        // Reset mid-window, released while the input is quietly low.
        k = 0;
        do begin
            step();
            k++;
        end while (!(k >= 30 && (ph % 20) == 12) && k < 200);
        rst_n = 1'b0;
        #1;
        chk("midrst_hz", 32'(hz), 32'd0);
        chk("midrst_valid", 32'(mv), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        push(5, 1'b0);
        wait_valid(300, n);
        chk("reset_latency", 32'(n), 32'(GC + 1));

        // Edge sampled at gate_cnt=99 of window 1, then at gate_cnt=0 of window 3.
        en     = 1'b0;
        period = 0;
        lvl    = 1'b0;
        repeat (10) step();
        push(1, 1'b0);
        push(0, 1'b0);
        push(1, 1'b0);
        en = 1'b1;
        for (int s = 1; s <= 310; s++) begin
            step();
            if (s == 97)  lvl = 1'b1;
            if (s == 149) lvl = 1'b0;
            if (s == 198) lvl = 1'b1;
        end
        chk("boundary_pending", 32'(sb.size()), 32'd0);
        en = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
